// File: rtl/amp3_frame_feeder.sv
// rtl/amp3_frame_feeder.sv - stereo frame FIFO feeding the AMP3 serializer
//
// Buffers 12-bit right/left frames from a producer and hands one frame to the
// serializer each time its RightNLeft output falls (end of a stereo frame).
// Playback starts once START_LEVEL frames are buffered. An empty FIFO on a
// frame boundary while playing emits SILENCE and is counted as an underrun.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   run                1 = play, 0 = stop after draining the FIFO
//   flush              pulse, discards FIFO contents (same-cycle push dropped)
//   wr_valid/wr_ready  producer handshake, wr_ready = not full
//   wr_dataR/wr_dataL  frame pushed on a handshake
//   RightNLeft         channel indicator from the serializer
//   dataR/dataL        registered frame presented to the serializer
//   enable             registered serializer enable (RUN or DRAIN)
//   level              frames currently stored, 0..DEPTH
//   underrun           one-cycle pulse on an empty pop while playing
//   underrun_cnt       saturating underrun count, cleared only by rst

module amp3_frame_feeder #(
    parameter int          DEPTH       = 8,
    parameter int          START_LEVEL = 4,
    parameter logic [11:0] SILENCE     = 12'h000,
    localparam int         AW          = $clog2(DEPTH),
    localparam int         LW          = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [11:0]   wr_dataR,
    input  logic [11:0]   wr_dataL,
    input  logic          RightNLeft,
    output logic [11:0]   dataR,
    output logic [11:0]   dataL,
    output logic          enable,
    output logic [LW-1:0] level,
    output logic          underrun,
    output logic [7:0]    underrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    // Counters are one bit wider than the address so full and empty differ.
    logic [LW-1:0] wr_cnt;
    logic [LW-1:0] rd_cnt;
    logic [23:0]   mem [DEPTH];
    logic          rnl_q;

    logic bnd;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign level    = wr_cnt - rd_cnt;
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign wr_ready = ~full;

    // Serializer finished a stereo frame: RightNLeft fell.
    assign bnd  = rnl_q & ~RightNLeft;
    assign push = wr_valid & ~full & ~flush;
    assign pop  = bnd & ((state == S_RUN) | (state == S_DRAIN));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (run) state_nx = S_PRIME;
            end
            S_PRIME: begin
                if (!run)                           state_nx = S_IDLE;
                else if (level >= LW'(START_LEVEL)) state_nx = S_RUN;
            end
            S_RUN: begin
                if (!run) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (run)              state_nx = S_RUN;
                else if (bnd & empty) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            enable       <= 1'b0;
            rnl_q        <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            dataR        <= SILENCE;
            dataL        <= SILENCE;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            enable   <= (state_nx == S_RUN) | (state_nx == S_DRAIN);
            rnl_q    <= RightNLeft;
            underrun <= 1'b0;

            if (state == S_IDLE) begin
                dataR <= SILENCE;
                dataL <= SILENCE;
            end else if (pop) begin
                if (!empty) begin
                    dataR <= mem[rd_cnt[AW-1:0]][23:12];
                    dataL <= mem[rd_cnt[AW-1:0]][11:0];
                end else begin
                    dataR <= SILENCE;
                    dataL <= SILENCE;
                    // An empty pop while draining is the normal end of playback.
                    if (state == S_RUN) begin
                        underrun <= 1'b1;
                        if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                    end
                end
            end

            if (flush) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (push)         wr_cnt <= wr_cnt + LW'(1);
                if (pop & ~empty) rd_cnt <= rd_cnt + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_cnt[AW-1:0]] <= {wr_dataR, wr_dataL};
    end

endmodule

// File: tb/tb_amp3_frame_feeder.sv
// tb/tb_amp3_frame_feeder.sv - self-checking bench for amp3_frame_feeder

module tb_amp3_frame_feeder;

    localparam int DEPTH = 8;
    localparam int START = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [11:0] wr_dataR = 12'h000;
    logic [11:0] wr_dataL = 12'h000;
    logic        rnl = 1'b0;
    logic [11:0] dataR;
    logic [11:0] dataL;
    logic        enable;
    logic [3:0]  level;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    int n_chk = 0;
    int n_pass = 0;

    amp3_frame_feeder #(.DEPTH(DEPTH), .START_LEVEL(START), .SILENCE(12'h000)) dut (
        .clk(clk), .rst(rst), .run(run), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_dataR(wr_dataR), .wr_dataL(wr_dataL),
        .RightNLeft(rnl), .dataR(dataR), .dataL(dataL),
        .enable(enable), .level(level),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a frame queue plus a playback mode word.
    localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2, M_DRAIN = 3;
    logic [23:0] q[$];
    int          m_mode = M_IDLE;
    bit          m_rnl = 0;
    int          m_r = 0, m_l = 0, m_en = 0, m_un = 0, m_cnt = 0;

    task automatic model_edge();
        int  sz;
        bit  bnd;
        logic [23:0] f;
        sz   = q.size();
        bnd  = m_rnl && !rnl;
        m_un = 0;
        if (rst) begin
            q.delete();
            m_mode = M_IDLE; m_rnl = 0; m_r = 0; m_l = 0; m_en = 0; m_cnt = 0;
            return;
        end
        if (m_mode == M_IDLE) begin
            m_r = 0; m_l = 0;
        end else if (bnd && (m_mode == M_PLAY || m_mode == M_DRAIN)) begin
            if (sz > 0) begin
                f = q.pop_front();
                m_r = int'(f[23:12]); m_l = int'(f[11:0]);
            end else begin
                m_r = 0; m_l = 0;
                if (m_mode == M_PLAY) begin
                    m_un = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        if (flush) q.delete();
        else if (wr_valid && sz < DEPTH) q.push_back({wr_dataR, wr_dataL});
        case (m_mode)
            M_IDLE:  if (run) m_mode = M_PRIME;
            M_PRIME: if (!run) m_mode = M_IDLE; else if (sz >= START) m_mode = M_PLAY;
            M_PLAY:  if (!run) m_mode = M_DRAIN;
            default: if (run) m_mode = M_PLAY; else if (bnd && sz == 0) m_mode = M_IDLE;
        endcase
        m_en  = (m_mode == M_PLAY || m_mode == M_DRAIN) ? 1 : 0;
        m_rnl = rnl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; flush = 1'b0; wr_valid = 1'b0; rnl = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dataR"}, int'(dataR), 0);
        chk({tag, "_dataL"}, int'(dataL), 0);
        chk({tag, "_enable"}, int'(enable), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_wr_ready"}, int'(wr_ready), 1);
        chk({tag, "_underrun_cnt"}, int'(underrun_cnt), 0);
    endtask

    task automatic push_frame(input logic [11:0] r, input logic [11:0] l);
        wr_valid = 1'b1; wr_dataR = r; wr_dataL = l;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic boundary();
        rnl = 1'b1; step();
        rnl = 1'b0; step();
    endtask

    typedef struct {
        logic        run;
        logic        push;
        logic [11:0] r;
        logic [11:0] l;
        logic        rnl;
        int          en;
        int          lvl;
        int          er;
        int          el;
        int          un;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rn, input logic p, input logic [11:0] r, input logic [11:0] l,
                       input logic rl, input int en, input int lvl, input int er, input int el,
                       input int un);
        vec_t v;
        v.run = rn; v.push = p; v.r = r; v.l = l; v.rnl = rl;
        v.en = en; v.lvl = lvl; v.er = er; v.el = el; v.un = un;
        tbl.push_back(v);
    endtask

    initial begin
        int half;
        int rate;

        // Prime, play with a concurrent push+pop, then drain to idle.
        add(1, 0, 12'h000, 12'h000, 0, 0, 0, 'h000, 'h000, 0);
        add(1, 1, 12'hFFF, 12'h000, 0, 0, 1, 'h000, 'h000, 0);
        add(1, 1, 12'h111, 12'h222, 0, 0, 2, 'h000, 'h000, 0);
        add(1, 1, 12'h333, 12'h444, 0, 0, 3, 'h000, 'h000, 0);
        add(1, 1, 12'h555, 12'h666, 0, 0, 4, 'h000, 'h000, 0);
        add(1, 0, 12'h000, 12'h000, 1, 1, 4, 'h000, 'h000, 0);
        add(1, 0, 12'h000, 12'h000, 0, 1, 3, 'hFFF, 'h000, 0);
        add(1, 0, 12'h000, 12'h000, 0, 1, 3, 'hFFF, 'h000, 0);
        add(1, 1, 12'h777, 12'h888, 1, 1, 4, 'hFFF, 'h000, 0);
        add(1, 1, 12'h999, 12'hAAA, 0, 1, 4, 'h111, 'h222, 0);
        add(1, 0, 12'h000, 12'h000, 1, 1, 4, 'h111, 'h222, 0);
        add(1, 0, 12'h000, 12'h000, 0, 1, 3, 'h333, 'h444, 0);
        add(1, 0, 12'h000, 12'h000, 1, 1, 3, 'h333, 'h444, 0);
        add(1, 0, 12'h000, 12'h000, 0, 1, 2, 'h555, 'h666, 0);
        add(0, 0, 12'h000, 12'h000, 1, 1, 2, 'h555, 'h666, 0);
        add(0, 0, 12'h000, 12'h000, 0, 1, 1, 'h777, 'h888, 0);
        add(0, 0, 12'h000, 12'h000, 1, 1, 1, 'h777, 'h888, 0);
        add(0, 0, 12'h000, 12'h000, 0, 1, 0, 'h999, 'hAAA, 0);
        add(0, 0, 12'h000, 12'h000, 1, 1, 0, 'h999, 'hAAA, 0);
        add(0, 0, 12'h000, 12'h000, 0, 0, 0, 'h000, 'h000, 0);

        do_reset();
        check_reset_state("reset");

        foreach (tbl[i]) begin
            run = tbl[i].run; wr_valid = tbl[i].push;
            wr_dataR = tbl[i].r; wr_dataL = tbl[i].l; rnl = tbl[i].rnl;
            step();
            chk($sformatf("tbl%0d_enable", i), int'(enable), tbl[i].en);
            chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
            chk($sformatf("tbl%0d_dataR", i), int'(dataR), tbl[i].er);
            chk($sformatf("tbl%0d_dataL", i), int'(dataL), tbl[i].el);
            chk($sformatf("tbl%0d_underrun", i), int'(underrun), tbl[i].un);
        end
        wr_valid = 1'b0;

        // Full FIFO: ninth frame must be refused and held off.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_dataR = 12'(i + 1); wr_dataL = 12'(i + 16);
            chk($sformatf("full_ready%0d", i), int'(wr_ready), (i < 8) ? 1 : 0);
            step();
            chk($sformatf("full_level%0d", i), int'(level), (i < 8) ? i + 1 : 8);
        end
        wr_valid = 1'b0;

        // Underrun in play, then saturation of the counter.
        do_reset();
        run = 1'b1; step();
        for (int i = 0; i < 4; i++) push_frame(12'hA00 + 12'(i), 12'h500 + 12'(i));
        step();
        chk("ur_enable", int'(enable), 1);
        for (int i = 0; i < 4; i++) boundary();
        chk("ur_last_dataR", int'(dataR), 'hA03);
        chk("ur_level_empty", int'(level), 0);
        boundary();
        chk("ur_pulse", int'(underrun), 1);
        chk("ur_dataR", int'(dataR), 0);
        chk("ur_dataL", int'(dataL), 0);
        chk("ur_cnt1", int'(underrun_cnt), 1);
        step();
        chk("ur_pulse_end", int'(underrun), 0);
        chk("ur_still_run", int'(enable), 1);
        for (int i = 0; i < 300; i++) boundary();
        chk("ur_cnt_sat", int'(underrun_cnt), 255);

        // Flush in play drops a same-cycle push; next boundary underruns.
        do_reset();
        run = 1'b1; step();
        for (int i = 0; i < 5; i++) push_frame(12'h0C0 + 12'(i), 12'h0D0 + 12'(i));
        chk("fl_level5", int'(level), 5);
        chk("fl_enable", int'(enable), 1);
        flush = 1'b1; wr_valid = 1'b1; wr_dataR = 12'h123; wr_dataL = 12'h456;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        chk("fl_level0", int'(level), 0);
        step();
        chk("fl_enable_kept", int'(enable), 1);
        boundary();
        chk("fl_underrun", int'(underrun), 1);
        chk("fl_cnt", int'(underrun_cnt), 1);
        push_frame(12'h321, 12'h654);
        do_reset();
        check_reset_state("midrun_reset");

        // Randomized traffic against the queue model.
        do_reset();
        run = 1'b1; half = 3; rate = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rate = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 90 : 50);
            if (--half == 0) begin
                rnl = ~rnl;
                half = int'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 199) == 0) run = ~run;
            flush = ($urandom_range(0, 249) == 0) && !(m_rnl && !rnl);
            wr_valid = ($urandom_range(0, 99) < rate);
            wr_dataR = 12'($urandom);
            wr_dataL = 12'($urandom);
            step();
            chk("rnd_dataR", int'(dataR), m_r);
            chk("rnd_dataL", int'(dataL), m_l);
            chk("rnd_enable", int'(enable), m_en);
            chk("rnd_level", int'(level), q.size());
            chk("rnd_wr_ready", int'(wr_ready), (q.size() < DEPTH) ? 1 : 0);
            chk("rnd_underrun", int'(underrun), m_un);
            chk("rnd_underrun_cnt", int'(underrun_cnt), m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
